// File: rtl/mul_share_sched_if.sv
// Client-side request/response bundle for the shared multiplier scheduler.
// Master = client blocks, slave = scheduler.
interface mul_share_sched_if #(
  parameter int unsigned SIZE = 4,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*SIZE-1:0] req_a;
  logic [NREQ*SIZE-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [2*SIZE-1:0]    rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one external pipelined multiplier among NREQ
// requesters; a tag pipeline carries each op's requester id alongside the product.
module mul_share_sched #(
  parameter  int unsigned SIZE = 4,
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned LAT  = 4,
  parameter  int unsigned IDW  = $clog2(NREQ),
  localparam int unsigned CNTW = $clog2(LAT + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  mul_share_sched_if.slave     bus,
  output logic [SIZE-1:0]      o_mul_a,
  output logic [SIZE-1:0]      o_mul_b,
  input  logic [2*SIZE-1:0]    i_mul_out,
  output logic [CNTW-1:0]      o_inflight,
  output logic                 o_idle
);

  logic [IDW-1:0]    r_rr_ptr;
  logic [LAT-1:0]    r_tag_vld;
  logic [IDW-1:0]    r_tag_id [LAT];
  logic [SIZE-1:0]   r_mul_a;
  logic [SIZE-1:0]   r_mul_b;
  logic              r_rsp_valid;
  logic [IDW-1:0]    r_rsp_id;
  logic [2*SIZE-1:0] r_rsp_data;
  logic [CNTW-1:0]   r_inflight;
  logic              r_idle;

  logic              w_found;
  logic [IDW-1:0]    w_gnt_id;
  logic [NREQ-1:0]   w_grant;
  logic              w_accept;
  logic [SIZE-1:0]   w_op_a;
  logic [SIZE-1:0]   w_op_b;
  logic [IDW-1:0]    w_rr_nxt;
  logic [CNTW-1:0]   w_inflight_nxt;

  // Requester index base+off wrapped modulo NREQ (both operands are < NREQ).
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // First valid requester at or after rr_ptr wins the grant.
  always_comb begin : grant_search
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_grant  = '0;
    if (i_en) begin
      for (int unsigned n = 0; n < NREQ; n++) begin
        if (!w_found && bus.req_valid[rr_index(r_rr_ptr, n)]) begin
          w_found  = 1'b1;
          w_gnt_id = rr_index(r_rr_ptr, n);
        end
      end
    end
    if (w_found) w_grant[w_gnt_id] = 1'b1;
  end

  // A grant is only ever given to a valid requester, so a grant is an accept.
  assign w_accept      = w_found;
  assign bus.req_ready = w_grant;
  assign w_op_a        = bus.req_a[32'(w_gnt_id) * SIZE +: SIZE];
  assign w_op_b        = bus.req_b[32'(w_gnt_id) * SIZE +: SIZE];
  assign w_rr_nxt      = (32'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + IDW'(1);

  // Occupancy counts an op from its accept through its response pulse cycle.
  always_comb begin : inflight_next
    w_inflight_nxt = r_inflight;
    if (w_accept && !r_rsp_valid) begin
      w_inflight_nxt = r_inflight + CNTW'(1);
    end else if (!w_accept && r_rsp_valid) begin
      w_inflight_nxt = r_inflight - CNTW'(1);
    end
  end

  // Operand issue and round-robin pointer.
  always_ff @(posedge clk) begin : issue_reg
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_rr_nxt;
      r_mul_a  <= w_op_a;
      r_mul_b  <= w_op_b;
    end else begin
      r_mul_a  <= '0;
      r_mul_b  <= '0;
    end
  end

  // Tag pipeline, matched to the multiplier latency.
  always_ff @(posedge clk) begin : tag_pipe
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_vld[0] <= w_accept;
      r_tag_id[0]  <= w_accept ? w_gnt_id : '0;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  // Response capture; id/data hold between pulses.
  always_ff @(posedge clk) begin : rsp_reg
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (r_tag_vld[LAT-1]) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_tag_id[LAT-1];
      r_rsp_data  <= i_mul_out;
    end else begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin : occupancy_reg
    if (!rst_n) begin
      r_inflight <= '0;
      r_idle     <= 1'b1;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_idle     <= (w_inflight_nxt == '0);
    end
  end

  assign o_mul_a       = r_mul_a;
  assign o_mul_b       = r_mul_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign o_inflight    = r_inflight;
  assign o_idle        = r_idle;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_grant));
  a_inflight_max  : assert property (@(posedge clk) disable iff (!rst_n)
                                     r_inflight <= CNTW'(LAT + 1));
  a_rsp_accounted : assert property (@(posedge clk) disable iff (!rst_n)
                                     r_rsp_valid |-> (r_inflight != '0));

endmodule

// File: tb/tb_mul_share_sched.sv
// Randomized bench for mul_share_sched: a queue-based reference model predicts
// grants, operand issue, response timing/order, occupancy and idle.
module tb_mul_share_sched;
  localparam int unsigned SIZE = 4;
  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CNTW = $clog2(LAT + 2);

  typedef struct {
    int                id;
    logic [2*SIZE-1:0] prod;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [SIZE-1:0]   mul_a, mul_b;
  logic [2*SIZE-1:0] mul_out;
  logic [CNTW-1:0]   inflight;
  logic              idle;

  mul_share_sched_if #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW)) bus ();

  mul_share_sched #(.SIZE(SIZE), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .bus        (bus),
    .o_mul_a    (mul_a),
    .o_mul_b    (mul_b),
    .i_mul_out  (mul_out),
    .o_inflight (inflight),
    .o_idle     (idle)
  );

  always #5 clk = ~clk;

  // External multiplier: the registered operands count as its first stage.
  logic [2*SIZE-1:0] mpipe [LAT-1];
  always @(posedge clk) begin
    mpipe[0] <= (2*SIZE)'(mul_a) * (2*SIZE)'(mul_b);
    for (int i = 1; i < LAT - 1; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_out = mpipe[LAT-2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  exp_t              q[$];
  int                rr = 0;
  int                cyc = 0;
  logic [SIZE-1:0]   exp_ma = '0, exp_mb = '0;
  int                last_id = 0;
  logic [2*SIZE-1:0] last_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic step(input logic e, input logic [NREQ-1:0] v,
                      input logic [NREQ*SIZE-1:0] a, input logic [NREQ*SIZE-1:0] b,
                      input logic rst);
    int k;
    int occ;
    logic [NREQ-1:0] exp_rdy;
    logic [SIZE-1:0] ak, bk;
    exp_t ent;
    @(negedge clk);
    rst_n         = ~rst;
    en            = e;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    #1;
    k = -1;
    if (e) begin
      for (int n = 0; n < int'(NREQ); n++) begin
        if (k < 0 && v[(rr + n) % NREQ]) k = (rr + n) % NREQ;
      end
    end
    exp_rdy = (k >= 0) ? (NREQ'(1) << k) : '0;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check_eq("mul_a", 32'(mul_a), 32'(exp_ma));
    check_eq("mul_b", 32'(mul_b), 32'(exp_mb));
    occ = q.size();
    check_eq("inflight", 32'(inflight), 32'(occ));
    check_eq("idle", 32'(idle), 32'(occ == 0));
    if (q.size() > 0 && q[0].due == cyc) begin
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      last_id   = q[0].id;
      last_data = q[0].prod;
      void'(q.pop_front());
    end else begin
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    check_eq("rsp_id", 32'(bus.rsp_id), 32'(last_id));
    check_eq("rsp_data", 32'(bus.rsp_data), 32'(last_data));
    if (rst) begin
      q.delete();
      rr = 0; exp_ma = '0; exp_mb = '0; last_id = 0; last_data = '0;
    end else if (k >= 0) begin
      ak = a[k*SIZE +: SIZE];
      bk = b[k*SIZE +: SIZE];
      ent.id   = k;
      ent.prod = (2*SIZE)'(ak) * (2*SIZE)'(bk);
      ent.due  = cyc + int'(LAT) + 1;
      q.push_back(ent);
      rr = (k + 1) % NREQ;
      exp_ma = ak; exp_mb = bk;
    end else begin
      exp_ma = '0; exp_mb = '0;
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(posedge clk);

    // Single op from requester 0: 3*5.
    idle_cycles(1);
    step(1'b1, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd3}, {4'd0, 4'd0, 4'd0, 4'd5}, 1'b0);
    idle_cycles(7);

    // Requesters 0 and 2 contend continuously; includes 15*15.
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'b0101, {4'd0, 4'd15, 4'd0, 4'd12}, {4'd0, 4'd15, 4'd0, 4'd6}, 1'b0);
    idle_cycles(7);

    // All four requesting for 8 cycles; occupancy reaches LAT+1.
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'b1111, {4'd9, 4'd7, 4'd15, 4'd2}, {4'd11, 4'd4, 4'd1, 4'd13}, 1'b0);
    idle_cycles(7);

    // Enable low blocks grants; pointer retained when enable returns.
    step(1'b1, 4'b0010, {4'd0, 4'd0, 4'd6, 4'd0}, {4'd0, 4'd0, 4'd7, 4'd0}, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 4'b1111, {4'd1, 4'd2, 4'd3, 4'd4}, {4'd5, 4'd6, 4'd7, 4'd8}, 1'b0);
    for (int i = 0; i < 2; i++)
      step(1'b1, 4'b1111, {4'd1, 4'd2, 4'd3, 4'd4}, {4'd5, 4'd6, 4'd7, 4'd8}, 1'b0);
    idle_cycles(7);

    // Reset while three ops are in flight discards them.
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'b1111, {4'd14, 4'd13, 4'd12, 4'd11}, {4'd3, 4'd3, 4'd3, 4'd3}, 1'b0);
    idle_cycles(1);
    step(1'b1, 4'b0000, '0, '0, 1'b1);
    idle_cycles(7);

    // Accept then drop enable: the in-flight op still drains.
    step(1'b1, 4'b1000, {4'd10, 4'd0, 4'd0, 4'd0}, {4'd10, 4'd0, 4'd0, 4'd0}, 1'b0);
    for (int i = 0; i < 7; i++)
      step(1'b0, 4'b1111, {4'd10, 4'd1, 4'd1, 4'd1}, {4'd10, 4'd1, 4'd1, 4'd1}, 1'b0);

    // Randomized traffic with occasional enable drops and resets.
    for (int i = 0; i < 600; i++)
      step(($urandom % 8) != 0, NREQ'($urandom), (NREQ*SIZE)'($urandom),
           (NREQ*SIZE)'($urandom), ($urandom % 64) == 0);
    idle_cycles(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Round-robin scheduler that shares one external pipelined multiplier (multi_pipe, fixed latency LAT) among NREQ requesters.
- Accepts operand pairs via per-requester valid/ready handshakes and issues at most one multiply per cycle.
- Tracks each issued operation's requester ID through a tag pipeline matched to the multiplier latency.
- Returns each product on a shared response bus tagged with the requester ID. Sits between the client blocks and the multiplier instance.

Parameters:
- size, 4, operand width in bits.
- NREQ, 4, number of requesters (2..8).
- LAT, 4, multiplier latency: mul_out reflects the mul_a/mul_b values presented LAT rising edges earlier.
- IDW, 2, requester ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  issue enable; 0 blocks new grants, in-flight ops still complete.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*size  flattened operand A; requester i uses bits [i*size +: size].
- req_b  in  NREQ*size  flattened operand B, same packing.
- req_ready  out  NREQ  grant vector, combinational, one-hot or zero.
- mul_a  out  size  registered operand A to the multiplier.
- mul_b  out  size  registered operand B to the multiplier.
- mul_out  in  2*size  multiplier product.
- rsp_valid  out  1  registered response valid, single-cycle pulse per op.
- rsp_id  out  IDW  requester ID of the response.
- rsp_data  out  2*size  product.
- inflight  out  clog2(LAT+2)  number of accepted ops not yet responded.
- idle  out  1  high when inflight==0.

Behaviour:
- Reset (rst_n=0 at an edge): rr_ptr=0, tag pipeline cleared, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, inflight=0, idle=1.
- Reset mid-operation discards all in-flight ops; no response is ever emitted for them.
- Grant (combinational):
  - If en=1, search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - The first set bit k gets req_ready[k]=1; all other bits are 0.
  - If en=0 or no request is valid, req_ready=0.
- Accept: at the edge where req_valid[k] & req_ready[k] holds:
  - mul_a/mul_b take requester k's operands.
  - rr_ptr becomes (k+1) mod NREQ.
  - Tag stage 0 is loaded with {1,k}.
- No accept at an edge: mul_a/mul_b are driven to 0, tag stage 0 loads {0,0}, rr_ptr is unchanged.
- Tag pipeline: LAT stages of {valid,id}, shifting every cycle.
- Response: at the edge after the final tag stage holds {1,id}, rsp_valid=1, rsp_id=id and rsp_data=mul_out are registered. Otherwise rsp_valid=0 and rsp_id/rsp_data hold their previous values.
- Latency: rsp_valid is high in cycle t+LAT+1 for an op accepted in cycle t. Throughput is one op per cycle, back-to-back.
- inflight: +1 on accept, -1 on response pulse. Simultaneous accept and response leave it unchanged. Maximum value is LAT+1.
- No response backpressure: consumers must sink every rsp_valid pulse.
- A requester keeping req_valid high with the same operands is accepted once per grant. Fairness: with all NREQ requesting, each is granted exactly once per NREQ cycles.
- Arithmetic: the product is unsigned, width 2*size, with no truncation; 4'hF*4'hF gives 8'hE1.
- en falling mid-stream: no new grants, outstanding ops drain in order, and idle rises the cycle after the last rsp_valid pulse.

Test Plan:
- Reset, then requester 0 issues a=3, b=5 in cycle t -> req_ready=4'b0001 in t; rsp_valid=1, rsp_id=0, rsp_data=8'h0F in t+5; idle=0 during t+1..t+5, idle=1 again from t+6.
- Requesters 0 and 2 both valid continuously with req0 a=12,b=6 and req2 a=15,b=15 -> grants alternate 0,2,0,2. Responses in the same order with data 8'h48, 8'hE1, ..., one per cycle.
- All four requesters valid for 8 cycles starting with rr_ptr=1 -> grant order 1,2,3,0,1,2,3,0. Exactly 8 responses with matching ids; inflight peaks at 5.
- en=0 while req_valid=4'b1111 -> req_ready=0, no responses. Set en=1 -> grants resume from the retained rr_ptr.
- 3 ops accepted, then rst_n=0 for one edge two cycles later -> no rsp_valid pulses follow; inflight=0, idle=1, mul_a=mul_b=0.
- Accept, then drop en in the next cycle -> the in-flight op still responds at t+5; no further grants occur.
